mem_line_responder: RTL and testbench

Synthesisable, parametrised line-granular memory responder that sits on the `mem_req_*`/`mem_resp_*` port of the L1+victim-cache top, replacing the fixed 1-cycle behavioural model. It adds request backpressure, a run-time programmable per-request latency with in-order responses, out-of-range and misalignment error reporting, and a consistent little-endian line layout. It is used both in benches and on FPGA bring-up as the backing store for cache performance measurements.

---
 rtl/mem_model_pkg.sv | 26 ++
 rtl/resp_fifo.sv | 52 +++++
 rtl/mem_line_responder.sv | 107 ++++++++++
 tb/tb_mem_line_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and constants for the line-granular memory responder.
// The response-entry struct is sized from these defaults; the top's parameters default to them.
package mem_model_pkg;
   localparam int ADDR_WIDTH  = 32;
   localparam int LINE_BYTES  = 16;
   localparam int MEM_BYTES   = 4096;
   localparam int LAT_WIDTH   = 8;
   localparam int LINE_WIDTH  = LINE_BYTES * 8;
   localparam int OFFSET_BITS = $clog2(LINE_BYTES);
   localparam int NUM_LINES   = MEM_BYTES / LINE_BYTES;
   localparam int NOW_WIDTH   = LAT_WIDTH + 1;

   typedef struct packed {
      logic [LINE_WIDTH-1:0] rdata;
      logic                  err;
      logic [NOW_WIDTH-1:0]  due;
   } resp_entry_t;

   // Due or overdue when (now - due) is non-negative in NOW_WIDTH-bit two's complement.
   function automatic logic is_due(input logic [NOW_WIDTH-1:0] now,
                                   input logic [NOW_WIDTH-1:0] due);
      logic [NOW_WIDTH-1:0] diff;
      diff = now - due;
      return ~diff[NOW_WIDTH-1];
   endfunction
endpackage

// File: rtl/resp_fifo.sv
// In-order queue of pending responses; async reset empties it, entry storage is not reset.
module resp_fifo
   import mem_model_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  resp_entry_t      push_data,
   input  logic             pop,
   output resp_entry_t      pop_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   resp_entry_t      entries_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = entries_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) entries_q[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/mem_line_responder.sv
// Line-granular backing store with backpressure, per-request programmable latency and
// strictly in-order registered responses. Storage is accessed at acceptance time.
module mem_line_responder
   import mem_model_pkg::*;
#(
   parameter int ADDR_WIDTH   = mem_model_pkg::ADDR_WIDTH,
   parameter int LINE_BYTES   = mem_model_pkg::LINE_BYTES,
   parameter int MEM_BYTES    = mem_model_pkg::MEM_BYTES,
   parameter int QDEPTH       = 4,
   parameter int LAT_WIDTH    = mem_model_pkg::LAT_WIDTH,
   parameter bit INIT_PATTERN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LAT_WIDTH-1:0]    cfg_latency,
   input  logic                    mem_req_valid,
   output logic                    mem_req_ready,
   input  logic                    mem_req_rw,
   input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic [LINE_BYTES*8-1:0] mem_req_wdata,
   output logic                    mem_resp_valid,
   output logic [LINE_BYTES*8-1:0] mem_resp_rdata,
   output logic                    mem_resp_err
);
   localparam int LW    = LINE_BYTES * 8;
   localparam int OFF   = $clog2(LINE_BYTES);
   localparam int NL    = MEM_BYTES / LINE_BYTES;
   localparam int IDX_W = $clog2(NL);
   localparam int NOW_W = LAT_WIDTH + 1;
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   typedef logic [LW-1:0] line_store_t [NL];

   function automatic line_store_t init_image();
      line_store_t img;
      for (int l = 0; l < NL; l++) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            img[l][b*8 +: 8] = INIT_PATTERN ? 8'((l * LINE_BYTES + b) & 255) : 8'h00;
         end
      end
      return img;
   endfunction

   // Power-up image only; storage is deliberately never reset so writes survive rst_n.
   line_store_t store = init_image();

   logic [NOW_W-1:0]     now_q;
   logic                 run_q;
   logic                 accept;
   logic                 addr_err;
   logic [IDX_W-1:0]     idx;
   logic [LAT_WIDTH-1:0] lat_eff;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [CNT_W-1:0]     count;
   resp_entry_t          push_entry;
   resp_entry_t          head;

   assign addr_err = (mem_req_addr >= ADDR_WIDTH'(MEM_BYTES)) || (mem_req_addr[OFF-1:0] != '0);
   assign idx      = mem_req_addr[OFF +: IDX_W];
   assign lat_eff  = (cfg_latency == '0) ? LAT_WIDTH'(1) : cfg_latency;

   // Ready comes only from registered state; a same-cycle pop never raises it.
   assign mem_req_ready = run_q & (count < CNT_W'(QDEPTH));
   assign accept        = mem_req_valid & mem_req_ready;
   assign pop           = ~empty & is_due(now_q, head.due);

   always_comb begin
      push_entry     = '0;
      push_entry.err = addr_err;
      push_entry.due = now_q + {1'b0, lat_eff};
      if (!mem_req_rw && !addr_err) push_entry.rdata = store[idx];
   end

   always_ff @(posedge clk) begin
      if (accept && mem_req_rw && !addr_err) store[idx] <= mem_req_wdata;
   end

   resp_fifo #(.DEPTH(QDEPTH)) u_resp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept & ~full),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now_q          <= '0;
         run_q          <= 1'b0;
         mem_resp_valid <= 1'b0;
         mem_resp_rdata <= '0;
         mem_resp_err   <= 1'b0;
      end else begin
         now_q          <= now_q + 1'b1;
         run_q          <= 1'b1;
         mem_resp_valid <= pop;
         mem_resp_rdata <= pop ? head.rdata : '0;
         mem_resp_err   <= pop & head.err;
      end
   end
endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed and random requests against a byte-array model
// where each response lands at max(accept + latency, previous response + 1).
module tb_mem_line_responder;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [7:0]   cfg_latency = 8'd1;
   logic         mem_req_valid = 1'b0;
   logic         mem_req_ready;
   logic         mem_req_rw = 1'b0;
   logic [31:0]  mem_req_addr = '0;
   logic [127:0] mem_req_wdata = '0;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_rdata;
   logic         mem_resp_err;

   mem_line_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_latency    (cfg_latency),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .mem_resp_err   (mem_resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] rdata;
      logic         err;
      int           due;
   } exp_t;

   exp_t         exp_q[$];
   byte unsigned mem_b [4096];
   int           checks = 0;
   int           errors = 0;
   int           e = 0;
   int           last_due = -1000;
   bit           model_run = 0;
   bit           model_ready = 0;
   bit           acc_flag = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] addr);
      logic [127:0] r;
      for (int b = 0; b < 16; b++) r[b*8 +: 8] = mem_b[int'(addr) + b];
      return r;
   endfunction

   // One clock: present inputs, advance the model, then check outputs on the falling edge.
   task automatic do_cycle(input bit v, input bit rw, input logic [31:0] addr,
                           input logic [127:0] wd, input int lat);
      exp_t ent;
      int   leff;
      bit   bad;
      mem_req_valid = v;
      mem_req_rw    = rw;
      mem_req_addr  = addr;
      mem_req_wdata = wd;
      cfg_latency   = 8'(lat);
      acc_flag      = 0;
      if (v && model_ready) begin
         acc_flag  = 1;
         leff      = (lat == 0) ? 1 : lat;
         bad       = (addr >= 32'd4096) || (addr[3:0] != 4'd0);
         ent.err   = bad;
         ent.rdata = '0;
         ent.due   = (e + 1 + leff > last_due + 1) ? e + 1 + leff : last_due + 1;
         last_due  = ent.due;
         if (!bad && !rw) ent.rdata = line_of(addr);
         if (!bad && rw) for (int b = 0; b < 16; b++) mem_b[int'(addr) + b] = wd[b*8 +: 8];
         exp_q.push_back(ent);
      end
      @(posedge clk);
      e++;
      if (rst_n) model_run = 1;
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == e) begin
         chk("resp_valid", 128'(mem_resp_valid), 128'(1));
         chk("resp_rdata", mem_resp_rdata, exp_q[0].rdata);
         chk("resp_err", 128'(mem_resp_err), 128'(exp_q[0].err));
         void'(exp_q.pop_front());
      end else begin
         chk("resp_valid_idle", 128'(mem_resp_valid), 128'(0));
      end
      model_ready = model_run && (exp_q.size() < 4);
      chk("req_ready", 128'(mem_req_ready), 128'(model_ready));
   endtask

   task automatic issue(input bit rw, input logic [31:0] addr, input logic [127:0] wd, input int lat);
      int n = 0;
      do begin
         do_cycle(1, rw, addr, wd, lat);
         n++;
      end while (!acc_flag && n < 200);
      chk("accept_timeout", 128'(acc_flag), 128'(1));
   endtask

   task automatic idle(input int n);
      repeat (n) do_cycle(0, 0, '0, '0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 1000) begin
         idle(1);
         n++;
      end
      chk("drain", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic apply_reset();
      rst_n         = 1'b0;
      mem_req_valid = 1'b0;
      #1;
      chk("rst_valid", 128'(mem_resp_valid), 128'(0));
      chk("rst_ready", 128'(mem_req_ready), 128'(0));
      chk("rst_rdata", mem_resp_rdata, 128'(0));
      chk("rst_err", 128'(mem_resp_err), 128'(0));
      exp_q.delete();
      last_due    = -1000;
      model_run   = 0;
      model_ready = 0;
      repeat (3) @(posedge clk);
      e += 3;
      @(negedge clk);
      chk("rst_hold_valid", 128'(mem_resp_valid), 128'(0));
      chk("rst_hold_ready", 128'(mem_req_ready), 128'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      logic [127:0] ln40;
      logic [31:0]  ra;
      int           r;
      for (int i = 0; i < 4096; i++) mem_b[i] = 8'(i);
      #1;
      apply_reset();

      // Legacy timing read of 0x40; first cycle after release also checks ready.
      idle(1);
      for (int b = 0; b < 16; b++) ln40[b*8 +: 8] = 8'(8'h40 + b);
      chk("init_line_40", line_of(32'h40), ln40);
      issue(0, 32'h40, '0, 1);
      drain();

      // Write then immediate long-latency read of the same line.
      issue(1, 32'h10, {96'h0, 32'hDEADBEEF}, 1);
      issue(0, 32'h10, '0, 20);
      drain();

      // Short request queued behind a long one.
      issue(0, 32'h20, '0, 10);
      issue(0, 32'h30, '0, 1);
      drain();

      // Queue fills at 4 outstanding; fifth waits for the first pop.
      for (int i = 0; i < 5; i++) issue(0, 32'(i * 16 + 32'h100), '0, 50);
      drain();

      // Error cases and latency zero.
      issue(0, 32'h1000, '0, 3);
      issue(0, 32'h04, '0, 1);
      issue(1, 32'h2000, {4{32'hA5A5A5A5}}, 2);
      issue(1, 32'h18, {4{32'h5A5A5A5A}}, 2);
      issue(0, 32'h0, '0, 0);
      issue(0, 32'h10, '0, 0);
      drain();

      // Reset with responses in flight.
      issue(0, 32'h50, '0, 30);
      issue(0, 32'h60, '0, 30);
      issue(1, 32'h70, {4{32'h01234567}}, 30);
      idle(2);
      apply_reset();
      idle(40);
      issue(0, 32'h10, '0, 1);
      issue(0, 32'h70, '0, 1);
      drain();

      // Random mix with gaps, RAW on a small line set and occasional errors.
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      ra = 32'h1000 + ($urandom_range(0, 255) << 4);
         else if (r == 1) ra = ($urandom_range(0, 255) << 4) | $urandom_range(1, 15);
         else if (r < 6)  ra = $urandom_range(0, 7) << 4;
         else             ra = $urandom_range(0, 255) << 4;
         issue(1'($urandom_range(0, 1)), ra, {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 12));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
